// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared constants for the single-lane I2S sender: default sample width, slot
// length and bit-clock divider, the AXI4-Stream data width, and the width of
// one sample-FIFO entry ({tlast, sample}).
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam int unsigned I2S_DATA_WIDTH   = 24;
    localparam int unsigned I2S_SLOT_BITS    = 32;
    localparam int unsigned I2S_BCLK_DIV     = 2;
    localparam int unsigned I2S_TDATA_WIDTH  = 32;
    localparam int unsigned I2S_FIFO_ENTRY_W = I2S_DATA_WIDTH + 1;

endpackage : i2s_pkg

// File: rtl/i2s_tx_sample_fifo.sv
// -----------------------------------------------------------------------------
// i2s_tx_sample_fifo
// Two-entry sample buffer between the AXI4-Stream slave and the serialiser.
// Full/empty are flops updated from the next occupancy, so the upstream
// tready is a registered signal.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push_i        write request (ignored while full)
//   push_data_i   entry to write
//   pop_i         read request (ignored while empty)
//   pop_data_o    head entry (valid while not empty)
//   full_o        both entries occupied
//   empty_o       no entry occupied
// -----------------------------------------------------------------------------
module i2s_tx_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = I2S_FIFO_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & ~empty_q;

    // Next-state: write at wr_ptr, advance pointers, recompute flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
        full_d  = (count_d == 2'd2);
        empty_d = (count_d == 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;

endmodule : i2s_tx_sample_fifo

// File: rtl/i2s_sender_lane.sv
// -----------------------------------------------------------------------------
// i2s_sender_lane
// Single-lane Philips I2S transmitter. Samples arrive on an AXI4-Stream slave,
// are buffered in a two-entry FIFO and shifted out MSB-first, one bit after
// each lrclk edge, changing on bclk falling edges.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   enable             run the serialiser; low parks all serial state at reset
//   s_axis_tvalid/tdata/tlast/tready
//                      sample stream; tdata[DATA_WIDTH-1:0] used, tlast marks
//                      the right-channel sample
//   i2s_sender_bclk    bit clock
//   i2s_sender_lrclk   word select (0 = left, 1 = right)
//   i2s_sender_sdata   serial data
//   underrun           sticky: a slot was loaded from an empty FIFO
//   misalign           sticky: popped tlast disagreed with the slot channel
//   err_clr            pulse clearing both sticky flags (a set in the same
//                      cycle wins)
//   frame_cnt          number of right-slot loads, wrapping
// -----------------------------------------------------------------------------
module i2s_sender_lane
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int unsigned SLOT_BITS  = I2S_SLOT_BITS,
    parameter int unsigned BCLK_DIV   = I2S_BCLK_DIV
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       s_axis_tvalid,
    input  logic [I2S_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       i2s_sender_bclk,
    output logic                       i2s_sender_lrclk,
    output logic                       i2s_sender_sdata,
    output logic                       underrun,
    output logic                       misalign,
    input  logic                       err_clr,
    output logic [15:0]                frame_cnt
);

    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;
    localparam int unsigned DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(SLOT_BITS);
    localparam int unsigned PAD_W   = SLOT_BITS - DATA_WIDTH;

    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic [SLOT_BITS-1:0] shifter_q, shifter_d;
    logic                 underrun_q, underrun_d;
    logic                 misalign_q, misalign_d;
    logic [15:0]          frame_q, frame_d;

    logic                  fe_c;
    logic                  fifo_pop_c;
    logic                  underrun_set_c;
    logic                  misalign_set_c;
    logic [ENTRY_W-1:0]    fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  rd_last;
    logic [DATA_WIDTH-1:0] rd_sample;

    // Only the low DATA_WIDTH bits of tdata carry audio.
    generate
        if (DATA_WIDTH < I2S_TDATA_WIDTH) begin : g_tdata_hi
            logic unused_tdata_hi;
            assign unused_tdata_hi = ^s_axis_tdata[I2S_TDATA_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    i2s_tx_sample_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (s_axis_tvalid),
        .push_data_i ({s_axis_tlast, s_axis_tdata[DATA_WIDTH-1:0]}),
        .pop_i       (fifo_pop_c),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rd_last   = fifo_rd_data[DATA_WIDTH];
    assign rd_sample = fifo_rd_data[DATA_WIDTH-1:0];

    // Divider, slot/bit counters, shifter load/shift and flag set events.
    always_comb begin
        div_d          = div_q;
        bit_d          = bit_q;
        bclk_d         = bclk_q;
        lrclk_d        = lrclk_q;
        sdata_d        = sdata_q;
        shifter_d      = shifter_q;
        frame_d        = frame_q;
        fe_c           = 1'b0;
        fifo_pop_c     = 1'b0;
        underrun_set_c = 1'b0;
        misalign_set_c = 1'b0;

        if (!enable) begin
            // Park serial state so re-enable starts a fresh left slot.
            div_d     = '0;
            bit_d     = BIT_W'(SLOT_BITS - 1);
            bclk_d    = 1'b0;
            lrclk_d   = 1'b1;
            sdata_d   = 1'b0;
            shifter_d = '0;
        end else begin
            if (div_q == DIV_W'(BCLK_DIV - 1)) begin
                div_d  = '0;
                bclk_d = ~bclk_q;
                fe_c   = bclk_q;
            end else begin
                div_d = div_q + DIV_W'(1);
            end

            if (fe_c) begin
                bit_d = (bit_q == BIT_W'(SLOT_BITS - 1)) ? '0 : bit_q + BIT_W'(1);
                if (bit_d == '0) begin
                    // Slot boundary: lrclk flips, one-bit I2S delay slot.
                    lrclk_d   = ~lrclk_q;
                    sdata_d   = 1'b0;
                    shifter_d = shifter_q << 1;
                end else if (bit_d == BIT_W'(1)) begin
                    fifo_pop_c = 1'b1;
                    if (fifo_empty) begin
                        shifter_d      = '0;
                        underrun_set_c = 1'b1;
                    end else begin
                        shifter_d      = {rd_sample, {PAD_W{1'b0}}};
                        misalign_set_c = (rd_last != lrclk_q);
                    end
                    sdata_d = shifter_d[SLOT_BITS-1];
                    if (lrclk_q) begin
                        frame_d = frame_q + 16'd1;
                    end
                end else begin
                    shifter_d = shifter_q << 1;
                    sdata_d   = shifter_d[SLOT_BITS-1];
                end
            end
        end

        underrun_d = (underrun_q & ~err_clr) | underrun_set_c;
        misalign_d = (misalign_q & ~err_clr) | misalign_set_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            bit_q      <= BIT_W'(SLOT_BITS - 1);
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b1;
            sdata_q    <= 1'b0;
            shifter_q  <= '0;
            underrun_q <= 1'b0;
            misalign_q <= 1'b0;
            frame_q    <= '0;
        end else begin
            div_q      <= div_d;
            bit_q      <= bit_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            shifter_q  <= shifter_d;
            underrun_q <= underrun_d;
            misalign_q <= misalign_d;
            frame_q    <= frame_d;
        end
    end

    assign s_axis_tready    = ~fifo_full;
    assign i2s_sender_bclk  = bclk_q;
    assign i2s_sender_lrclk = lrclk_q;
    assign i2s_sender_sdata = sdata_q;
    assign underrun         = underrun_q;
    assign misalign         = misalign_q;
    assign frame_cnt        = frame_q;

endmodule : i2s_sender_lane

// File: tb/tb_i2s_sender_lane.sv
// -----------------------------------------------------------------------------
// tb_i2s_sender_lane
// Self-checking bench: an I2S decoder reconstructs {channel, word} from the
// serial pins and directed/random sample streams are compared against the
// words the bench pushed.
// -----------------------------------------------------------------------------
module tb_i2s_sender_lane;

    localparam int DW = 24;
    localparam int SB = 32;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        i2s_sender_bclk;
    logic        i2s_sender_lrclk;
    logic        i2s_sender_sdata;
    logic        underrun;
    logic        misalign;
    logic        err_clr;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    i2s_sender_lane #(
        .DATA_WIDTH (DW),
        .SLOT_BITS  (SB),
        .BCLK_DIV   (BD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tready    (s_axis_tready),
        .i2s_sender_bclk  (i2s_sender_bclk),
        .i2s_sender_lrclk (i2s_sender_lrclk),
        .i2s_sender_sdata (i2s_sender_sdata),
        .underrun         (underrun),
        .misalign         (misalign),
        .err_clr          (err_clr),
        .frame_cnt        (frame_cnt)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Decoded words {lrclk, sample} and words expected from the pushes.
    logic [DW:0] dec_q [$];
    logic [DW:0] exp_q [$];
    int          pad_err = 0;

    // I2S decoder: sample data on each bclk rise; bit position counts from the
    // rise where lrclk changed; positions 1..DW are the word, the rest zero.
    logic        prev_bclk;
    logic        prev_lr;
    int          pos;
    logic [DW-1:0] acc;

    always @(negedge clk) begin
        if (rst) begin
            prev_bclk = 1'b0;
            prev_lr   = 1'b1;
            pos       = 100;
            acc       = '0;
        end else begin
            if (!prev_bclk && i2s_sender_bclk) begin
                if (i2s_sender_lrclk != prev_lr) pos = 0;
                else                             pos = pos + 1;
                prev_lr = i2s_sender_lrclk;
                if (pos >= 1 && pos <= DW) begin
                    acc = {acc[DW-2:0], i2s_sender_sdata};
                    if (pos == DW) dec_q.push_back({i2s_sender_lrclk, acc});
                end else if (pos < SB && i2s_sender_sdata !== 1'b0) begin
                    pad_err = pad_err + 1;
                end
            end
            prev_bclk = i2s_sender_bclk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for tready (bounded), then presents one beat for one cycle.
    task automatic push(input logic [31:0] data, input logic last, input int bound,
                        output int waited);
        waited = bound;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                waited = i;
                break;
            end
        end
        if (waited < bound) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = data;
            s_axis_tlast  = last;
            @(negedge clk);
            s_axis_tvalid = 1'b0;
        end
    endtask

    task automatic wait_words(input int n, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            if (dec_q.size() >= n) break;
            @(negedge clk);
        end
        check(tag, 32'(dec_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        enable        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        err_clr       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dec_q.delete();
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        logic [31:0] w;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;

        // ---- reset values ----
        do_reset();
        check("rst_bclk", 32'(i2s_sender_bclk), 32'd0);
        check("rst_lrclk", 32'(i2s_sender_lrclk), 32'd1);
        check("rst_sdata", 32'(i2s_sender_sdata), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // ---- directed frame 0xABCDEF / 0x123456 with start-up timing ----
        push(32'h5AABCDEF, 1'b0, 20, waited);
        push(32'hC3123456, 1'b1, 20, waited);
        enable = 1'b1;
        for (int k = 1; k <= 2 * BD + 1; k++) begin
            @(negedge clk);
            check("startup_bclk", 32'(i2s_sender_bclk), 32'((k / BD) % 2));
            check("startup_lrclk", 32'(i2s_sender_lrclk), (k < 2 * BD) ? 32'd1 : 32'd0);
        end
        wait_words(2, 800, "dir_timeout");
        check("dir_left", 32'(dec_q[0]), 32'({1'b0, 24'hABCDEF}));
        check("dir_right", 32'(dec_q[1]), 32'({1'b1, 24'h123456}));
        check("dir_frame_cnt", 32'(frame_cnt), 32'd1);
        check("dir_underrun", 32'(underrun), 32'd0);
        check("dir_misalign", 32'(misalign), 32'd0);

        // ---- continuous random stream of 8 frames ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            exp_q.push_back({1'(i % 2), w[DW-1:0]});
            if (i == 2) enable = 1'b1;
            push(w, 1'(i % 2), 400, waited);
            check("stream_push", 32'(waited < 400), 32'd1);
        end
        wait_words(16, 3000, "stream_timeout");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("stream_word%0d", i), 32'(dec_q[i]), 32'(exp_q[i]));
        end
        check("stream_frame_cnt", 32'(frame_cnt), 32'd8);
        check("stream_underrun", 32'(underrun), 32'd0);
        check("stream_misalign", 32'(misalign), 32'd0);

        // ---- underrun from empty FIFO, clear, set again ----
        do_reset();
        enable = 1'b1;
        repeat (4 * BD - 1) @(negedge clk);
        check("ur_before_load", 32'(underrun), 32'd0);
        @(negedge clk);
        check("ur_at_left_load", 32'(underrun), 32'd1);
        pulse_err_clr();
        check("ur_cleared", 32'(underrun), 32'd0);
        repeat (SB * 2 * BD) @(negedge clk);
        check("ur_right_load", 32'(underrun), 32'd1);
        check("ur_frame_cnt", 32'(frame_cnt), 32'd1);
        wait_words(2, 400, "ur_timeout");
        check("ur_left_zero", 32'(dec_q[0]), 32'({1'b0, 24'h0}));
        check("ur_right_zero", 32'(dec_q[1]), 32'({1'b1, 24'h0}));

        // ---- misalign: left word carries tlast=1 ----
        do_reset();
        w1 = $urandom;
        w2 = $urandom;
        push(w1, 1'b1, 20, waited);
        push(w2, 1'b1, 20, waited);
        enable = 1'b1;
        wait_words(1, 400, "mis_timeout");
        check("mis_left_data", 32'(dec_q[0]), 32'({1'b0, w1[DW-1:0]}));
        check("mis_flag", 32'(misalign), 32'd1);
        check("mis_underrun", 32'(underrun), 32'd0);
        pulse_err_clr();
        check("mis_cleared", 32'(misalign), 32'd0);
        wait_words(2, 400, "mis_timeout2");
        check("mis_right_data", 32'(dec_q[1]), 32'({1'b1, w2[DW-1:0]}));
        check("mis_right_ok", 32'(misalign), 32'd0);

        // ---- FIFO full while disabled, accept after first pop ----
        do_reset();
        w1 = $urandom;
        w2 = $urandom;
        w3 = $urandom;
        push(w1, 1'b0, 20, waited);
        check("full_tready_1", 32'(s_axis_tready), 32'd1);
        push(w2, 1'b1, 20, waited);
        check("full_tready_2", 32'(s_axis_tready), 32'd0);
        push(w3, 1'b0, 20, waited);
        check("full_third_held", 32'(waited), 32'd20);
        check("full_tready_held", 32'(s_axis_tready), 32'd0);
        enable = 1'b1;
        push(w3, 1'b0, 200, waited);
        check("full_accept_delay", 32'(waited), 32'(4 * BD - 1));
        wait_words(3, 1200, "full_timeout");
        check("full_w1", 32'(dec_q[0]), 32'({1'b0, w1[DW-1:0]}));
        check("full_w2", 32'(dec_q[1]), 32'({1'b1, w2[DW-1:0]}));
        check("full_w3", 32'(dec_q[2]), 32'({1'b0, w3[DW-1:0]}));

        // ---- asynchronous reset mid right slot ----
        do_reset();
        push($urandom, 1'b0, 20, waited);
        push($urandom, 1'b1, 20, waited);
        enable = 1'b1;
        wait_words(1, 400, "ar_timeout");
        for (int i = 0; i < 400; i++) begin
            if (i2s_sender_lrclk) break;
            @(negedge clk);
        end
        push($urandom, 1'b0, 20, waited);
        repeat (10) @(negedge clk);
        check("ar_pre_frame_cnt", 32'(frame_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("ar_bclk", 32'(i2s_sender_bclk), 32'd0);
        check("ar_lrclk", 32'(i2s_sender_lrclk), 32'd1);
        check("ar_sdata", 32'(i2s_sender_sdata), 32'd0);
        check("ar_tready", 32'(s_axis_tready), 32'd1);
        check("ar_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dec_q.delete();
        repeat (4 * BD) @(negedge clk);
        check("ar_fifo_empty", 32'(underrun), 32'd1);

        // ---- enable drop mid left slot keeps FIFO contents ----
        do_reset();
        w1 = $urandom;
        w2 = $urandom;
        push(w1, 1'b0, 20, waited);
        push(w2, 1'b1, 20, waited);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_bclk", 32'(i2s_sender_bclk), 32'd0);
        check("dis_lrclk", 32'(i2s_sender_lrclk), 32'd1);
        check("dis_sdata", 32'(i2s_sender_sdata), 32'd0);
        check("dis_tready", 32'(s_axis_tready), 32'd1);
        repeat (10) @(negedge clk);
        enable = 1'b1;
        wait_words(1, 400, "dis_timeout");
        check("dis_resume_word", 32'(dec_q[0]), 32'({1'b0, w2[DW-1:0]}));
        check("dis_resume_misalign", 32'(misalign), 32'd1);

        check("pad_bits_zero", 32'(pad_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_i2s_sender_lane
